ex_pipe_unit: RTL

- Parametrised successor to the single-latch execute unit.
- Integer ALU followed by a STAGES-deep valid/ready output pipeline, sitting between the issue logic and the ROB/rename-register write port.
- Adds over the previous generation: configurable width, depth and tag size; backpressure from writeback; whole-pipeline flush on mispredict; bubble collapsing.

---
 rtl/ex_pipe_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/ex_pipe_unit.sv
// ex_pipe_unit: integer ALU feeding a STAGES-deep valid/ready result pipeline with flush and bubble collapsing.
// Optional perf counters (accepted ops, consumed heads) are enabled by defining EX_PIPE_PERF_CNT_EN.
module ex_pipe_unit #(
  parameter int DATA_LEN  = 32,
  parameter int STAGES    = 2,
  parameter int RRF_TAG_W = 6
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 issue_i,
  output logic                 issue_ready_o,
  input  logic [3:0]           alu_op_i,
  input  logic [DATA_LEN-1:0]  src1_i,
  input  logic [DATA_LEN-1:0]  src2_i,
  input  logic                 if_write_rrf_i,
  input  logic [RRF_TAG_W-1:0] rrf_tag_i,
  input  logic                 flush_i,
  input  logic                 out_ready_i,
  output logic [DATA_LEN-1:0]  result_o,
  output logic [RRF_TAG_W-1:0] rrf_tag_o,
  output logic                 reorder_buffer_we_o,
`ifdef EX_PIPE_PERF_CNT_EN
  output logic [31:0]          perf_issued_o,
  output logic [31:0]          perf_done_o,
`endif
  output logic                 rename_register_we_o
);
  localparam int SH   = $clog2(DATA_LEN);
  localparam int LAST = STAGES - 1;
  logic [SH-1:0]        shamt;
  logic [DATA_LEN-1:0]  alu_res;
  logic [STAGES-1:0]    valid, adv;
  logic [DATA_LEN-1:0]  res [STAGES];
  logic [RRF_TAG_W-1:0] tag [STAGES];
  logic [STAGES-1:0]    wr;
  logic                 accept;
  assign shamt = src2_i[SH-1:0];
  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      4'd0: alu_res = src1_i + src2_i;
      4'd1: alu_res = src1_i - src2_i;
      4'd2: alu_res = src1_i << shamt;
      4'd3: alu_res = DATA_LEN'($signed(src1_i) < $signed(src2_i));
      4'd4: alu_res = DATA_LEN'(src1_i < src2_i);
      4'd5: alu_res = src1_i ^ src2_i;
      4'd6: alu_res = src1_i >> shamt;
      4'd7: alu_res = $signed(src1_i) >>> shamt;
      4'd8: alu_res = src1_i | src2_i;
      4'd9: alu_res = src1_i & src2_i;
      default: alu_res = '0;
    endcase
  end
  // A stage may advance if it or any stage downstream of it is empty, or the head drains.
  always_comb begin
    adv = '0;
    for (int i = 0; i < STAGES; i++) adv[i] = out_ready_i || (|((~valid) >> i));
  end
  assign issue_ready_o = adv[0];
  assign accept        = issue_i && adv[0] && !flush_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      valid <= '0;
      wr    <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      if (flush_i) valid[0] <= 1'b0;
      else if (adv[0]) valid[0] <= accept;
      if (accept) begin
        res[0] <= alu_res;
        tag[0] <= rrf_tag_i;
        wr[0]  <= if_write_rrf_i;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (flush_i) valid[i] <= 1'b0;
        else if (adv[i]) valid[i] <= valid[i-1];
        if (adv[i] && valid[i-1]) begin
          res[i] <= res[i-1];
          tag[i] <= tag[i-1];
          wr[i]  <= wr[i-1];
        end
      end
    end
  assign result_o             = res[LAST];
  assign rrf_tag_o            = tag[LAST];
  assign reorder_buffer_we_o  = valid[LAST];
  assign rename_register_we_o = valid[LAST] && wr[LAST];
`ifdef EX_PIPE_PERF_CNT_EN
  logic done;
  assign done = valid[LAST] && out_ready_i && !flush_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      perf_issued_o <= '0;
      perf_done_o   <= '0;
    end else begin
      perf_issued_o <= perf_issued_o + 32'(accept);
      perf_done_o   <= perf_done_o + 32'(done);
    end
`endif
endmodule
